// File: rtl/throttle_curve_scheduler.sv
// Shares one throttle_curve instance round-robin among NUM_CH motor channels and
// registers each curved result per channel, with a per-channel signal-loss failsafe.
module throttle_curve_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int CURVE_LAT   = 1,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH*8-1:0]   i_thr_in,
    input  logic [NUM_CH-1:0]     i_thr_valid,
    output logic [7:0]            o_curve_in,
    input  logic [7:0]            i_curve_out,
    output logic [NUM_CH*8-1:0]   o_pwm_out,
    output logic [NUM_CH-1:0]     o_pwm_valid,
    output logic [NUM_CH-1:0]     o_timeout_flag,
    output logic                  o_busy
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int LAT_W = (CURVE_LAT > 1) ? $clog2(CURVE_LAT) : 1;
    localparam bit               TO_EN    = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_SAT   = CNT_W'(TIMEOUT_CYC);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CURVE_LAT - 1);
    localparam logic [CH_W:0]    NUM_CH_V = (CH_W + 1)'(NUM_CH);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_shadow [NUM_CH];
    logic [7:0]         r_pwm    [NUM_CH];
    logic [CNT_W-1:0]   r_cnt    [NUM_CH];
    logic [NUM_CH-1:0]  r_pend;
    logic [NUM_CH-1:0]  r_pwm_valid;
    logic [NUM_CH-1:0]  r_flag;
    logic [CH_W-1:0]    r_rr;
    logic [CH_W-1:0]    r_sel_ch;
    logic [7:0]         r_curve_in;
    logic [LAT_W-1:0]   r_lat;
    logic               r_discard;

    logic [NUM_CH-1:0]   w_to;
    logic [NUM_CH-1:0]   w_req;
    logic [NUM_CH-1:0]   w_rot;
    logic [2*NUM_CH-1:0] w_req2;
    logic [CH_W:0]       w_off;
    logic [CH_W:0]       w_sum;
    logic [CH_W-1:0]     w_grant_ch;
    logic [CH_W-1:0]     w_rr_nxt;
    logic                w_any_req;
    logic                w_grant;
    logic                w_done;

    // Failsafe fires on the edge where the idle counter would reach TIMEOUT_CYC
    always_comb begin
        w_to = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            w_to[i] = TO_EN && !i_thr_valid[i] && (r_cnt[i] == TO_LAST);
        end
    end

    // A channel going into failsafe this edge is not granted
    assign w_req     = r_pend & ~w_to;
    assign w_req2    = {w_req, w_req} >> r_rr;
    assign w_rot     = w_req2[NUM_CH-1:0];
    assign w_any_req = |w_rot;
    assign w_grant   = (r_state == ST_IDLE) && w_any_req;
    assign w_done    = (r_state == ST_WAIT) && (r_lat == LAT_LAST);

    // First requesting channel at or after the round-robin pointer
    always_comb begin
        w_off = {(CH_W + 1){1'b0}};
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_off = w_rot[k] ? (CH_W + 1)'(k) : w_off;
        end
        w_sum      = {1'b0, r_rr} + w_off;
        w_grant_ch = (w_sum >= NUM_CH_V) ? CH_W'(w_sum - NUM_CH_V) : w_sum[CH_W-1:0];
        w_rr_nxt   = (w_grant_ch == LAST_CH) ? {CH_W{1'b0}} : (w_grant_ch + CH_W'(1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) w_state_nxt = ST_WAIT;
                else         w_state_nxt = ST_IDLE;
            end
            ST_WAIT: begin
                if (w_done) w_state_nxt = ST_IDLE;
                else        w_state_nxt = ST_WAIT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant bookkeeping: selected channel, held curve input, pointer and WAIT timing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_ch   <= {CH_W{1'b0}};
            r_curve_in <= 8'd0;
            r_rr       <= {CH_W{1'b0}};
            r_lat      <= {LAT_W{1'b0}};
            r_discard  <= 1'b0;
        end else if (w_grant) begin
            r_sel_ch   <= w_grant_ch;
            r_curve_in <= r_shadow[w_grant_ch];
            r_rr       <= w_rr_nxt;
            r_lat      <= {LAT_W{1'b0}};
            r_discard  <= 1'b0;
        end else if (r_state == ST_WAIT) begin
            if (!w_done) r_lat <= r_lat + LAT_W'(1);
            // Channel dropped into failsafe while in flight: its result must not land
            if (w_to[r_sel_ch]) r_discard <= 1'b1;
        end
    end

    // Per-channel capture, failsafe counter and registered PWM outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= 8'd0;
                r_pwm[i]    <= 8'd0;
                r_cnt[i]    <= {CNT_W{1'b0}};
            end
            r_pend      <= {NUM_CH{1'b0}};
            r_pwm_valid <= {NUM_CH{1'b0}};
            r_flag      <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (i_thr_valid[i]) begin
                    r_shadow[i] <= i_thr_in[8*i +: 8];
                    r_pend[i]   <= 1'b1;
                    r_flag[i]   <= 1'b0;
                    r_cnt[i]    <= {CNT_W{1'b0}};
                end else begin
                    if (TO_EN && (r_cnt[i] != TO_SAT)) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    if (w_to[i]) begin
                        r_pend[i] <= 1'b0;
                        r_flag[i] <= 1'b1;
                    end else if (w_grant && (w_grant_ch == CH_W'(i))) begin
                        r_pend[i] <= 1'b0;
                    end
                end

                if (w_to[i]) begin
                    r_pwm[i]       <= 8'd0;
                    r_pwm_valid[i] <= 1'b1;
                end else if (w_done && !r_discard && (r_sel_ch == CH_W'(i))) begin
                    r_pwm[i]       <= i_curve_out;
                    r_pwm_valid[i] <= 1'b1;
                end else begin
                    r_pwm_valid[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign o_pwm_out[8*g +: 8] = r_pwm[g];
    end

    assign o_curve_in     = r_curve_in;
    assign o_pwm_valid    = r_pwm_valid;
    assign o_timeout_flag = r_flag;
    assign o_busy         = (r_state == ST_WAIT);

endmodule
